// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the rr_arb8 round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit after ptr, wrapping mod 8.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    logic [IDX_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    assign start = ptr + 3'd1;

    // rot[0] is the requester just after ptr, so the lowest set bit is the winner.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[start + IDX_W'(i)];
        end
    end

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign hit = |req;
    assign idx = start + off;

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with hold-until-done/drop ownership.
// Define RR_ARB8_TIMEOUT_EN to bound each hold to MAX_HOLD cycles with a timeout pulse.
module rr_arb8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req,
    output logic             timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_cfg_check
        $error("rr_arb8: MAX_HOLD must be 2..255 and fit in CNT_W bits");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_hit;
    logic             tmo_hit;
    logic             release_now;

`ifdef RR_ARB8_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    assign tmo_hit = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .hit (pick_hit)
    );

    assign any_req     = |req;
    assign release_now = done || !req[owner_q] || tmo_hit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= 3'd7;
`ifdef RR_ARB8_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
`ifdef RR_ARB8_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
`ifdef RR_ARB8_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_hit) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx;
`ifdef RR_ARB8_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d    = ST_IDLE;
                    ptr_d      = owner_q;
`ifdef RR_ARB8_TIMEOUT_EN
                    hold_cnt_d = '0;
                    // Only a pure expiry is reported; a normal release on the same edge wins.
                    timeout_d  = tmo_hit && !done && req[owner_q];
`endif
                end else begin
`ifdef RR_ARB8_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs derive only from registers, so gnt is glitch-free for LED logic.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (state_q == ST_GRANT) begin
            gnt       = idx_to_onehot(owner_q);
            gnt_valid = 1'b1;
            gnt_idx   = owner_q;
        end
    end

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: directed scenarios plus random traffic vs. a behavioural model.
module tb_rr_arb8;

`ifdef RR_ARB8_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 4;
    localparam bit TB_TMO      = 1'b1;
`else
    localparam int TB_MAX_HOLD = 16;
    localparam bit TB_TMO      = 1'b0;
`endif

    // clock / reset
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       any_req;
    logic       timeout;

    always #5 clk = ~clk;

    rr_arb8 #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .any_req   (any_req),
        .timeout   (timeout)
    );

    int checks   = 0;
    int failures = 0;

    // expected snapshot after each edge: {any_req, timeout, gnt_valid, gnt_idx}
    logic [5:0] exp_q[$];
    bit         mon_en = 1'b0;

    // behavioural model: owner (-1 = nobody), last owner, cycles held so far
    int m_owner = -1;
    int m_last  = 7;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input bit r, input logic [7:0] q, input bit d);
        bit cause_a, cause_b, cause_c;
        if (r) begin
            m_owner = -1;
            m_last  = 7;
            m_hold  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (q[c]) begin
                    m_owner = c;
                    m_hold  = 0;
                    break;
                end
            end
        end else begin
            cause_a = d;
            cause_b = !q[m_owner];
            cause_c = TB_TMO && (m_hold == TB_MAX_HOLD - 1);
            if (cause_a || cause_b || cause_c) begin
                m_to    = cause_c && !cause_a && !cause_b;
                m_last  = m_owner;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
    endfunction

    // driver: one clock cycle of stimulus, expected result queued for the monitor
    task automatic cyc(input bit r, input logic [7:0] q, input bit d);
        logic [2:0] e_idx;
        @(negedge clk);
        rst  = r;
        req  = q;
        done = d;
        model_step(r, q, d);
        e_idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        exp_q.push_back({(q != 8'h00), m_to, (m_owner >= 0), e_idx});
        mon_en = 1'b1;
        if (r) begin
            #1;
            check("rst_async_gnt", int'(gnt), 0);
            check("rst_async_valid", int'(gnt_valid), 0);
            check("rst_async_idx", int'(gnt_idx), 0);
            check("rst_async_timeout", int'(timeout), 0);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [5:0] e;
        logic [7:0] e_gnt;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue_empty: got 0 entries expected at least 1 at %0t", $time);
            end else begin
                e     = exp_q.pop_front();
                e_gnt = e[3] ? (8'h01 << e[2:0]) : 8'h00;
                check("gnt_idx", int'(gnt_idx), int'(e[2:0]));
                check("gnt_valid", int'(gnt_valid), int'(e[3]));
                check("timeout", int'(timeout), int'(e[4]));
                check("any_req", int'(any_req), int'(e[5]));
                check("gnt", int'(gnt), int'(e_gnt));
            end
        end
    end

    // stimulus
    initial begin
        logic [7:0] rq;
        int hold_target;
        hold_target = (TB_MAX_HOLD < 4) ? TB_MAX_HOLD - 1 : 3;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        cyc(1, 8'h00, 0);
        cyc(1, 8'h00, 0);

        // single requester, then reset while it owns the grant
        repeat (3) cyc(0, 8'h01, 0);
        cyc(1, 8'h01, 0);
        // after reset index 0 beats 7; 7 follows once 0 releases
        cyc(0, 8'h81, 0);
        cyc(0, 8'h81, 1);
        cyc(0, 8'h81, 0);
        cyc(0, 8'h81, 1);
        cyc(0, 8'h00, 0);

        // all requesting, done every grant: strict rotation with idle gaps
        cyc(1, 8'h00, 0);
        repeat (20) cyc(0, 8'hFF, (m_owner >= 0));

        // owner 3 released, 7 wins next, then 3 again
        cyc(1, 8'h00, 0);
        cyc(0, 8'h08, 0);
        repeat (2) cyc(0, 8'h88, 0);
        cyc(0, 8'h88, 1);
        repeat (8) cyc(0, 8'h88, (m_owner >= 0 && m_hold == 1));

        // owner 5 drops its request
        cyc(1, 8'h00, 0);
        repeat (2) cyc(0, 8'h20, 0);
        cyc(0, 8'h00, 0);
        repeat (3) cyc(0, 8'h21, 0);
        cyc(0, 8'h00, 0);

        // long hold with no done (expires in the timeout build)
        repeat (12) cyc(0, 8'h04, 0);
        cyc(0, 8'h00, 0);
        // done coinciding with the last permitted hold cycle
        repeat (8) cyc(0, 8'h04, (m_owner >= 0 && m_hold == hold_target));
        cyc(0, 8'h00, 0);
        // request drop coinciding with the last permitted hold cycle
        cyc(0, 8'h04, 0);
        repeat (8) cyc(0, (m_owner >= 0 && m_hold == hold_target) ? 8'h00 : 8'h04, 0);

        // done while idle with nothing requested
        cyc(0, 8'h00, 0);
        repeat (3) cyc(0, 8'h00, 1);

        // random traffic
        rq = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 6) == 0) rq = 8'($urandom_range(0, 255));
            cyc(($urandom_range(0, 149) == 0), rq, ($urandom_range(0, 4) == 0));
        end
        cyc(0, 8'h00, 0);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters (switch/LED-level board I/O, or any single-owner unit).
- Replaces fixed-priority encoding with fair rotation and owner hold/release.
- Registers the winner's one-hot grant and index, which downstream LED/segment logic consumes directly.
- Owner holds the grant until it signals done, drops its request, or (optionally) times out.

Parameters:
- N, 8, number of requesters (fixed at 8; IDX_W derived).
- IDX_W, 3, grant index width.
- MAX_HOLD, 16, max cycles an owner may hold the grant (timeout build only); legal range 2..255.
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  8  request vector, bit i = requester i
- done  in  1  current owner finished; one-cycle pulse, ignored when no grant
- gnt  out  8  one-hot grant, all zero when idle
- gnt_valid  out  1  1 iff gnt != 0
- gnt_idx  out  3  index of current owner, 0 when idle
- any_req  out  1  combinational OR of req
- timeout  out  1  one-cycle pulse when a hold is forcibly ended

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, ptr=7, hold_cnt=0. Reset applies immediately, including mid-grant.
- Registered state:
  - state: IDLE or GRANT.
  - ptr[2:0]: last owner.
  - owner[2:0].
  - hold_cnt[CNT_W-1:0].
- Pick function (combinational): first set bit of req searching ptr+1, ptr+2, ..., ptr+8, indices mod 8 (3-bit wrap). After reset, index 0 has top priority.
- IDLE:
  - If any_req, the next edge enters GRANT with owner=pick, gnt=1<<pick, hold_cnt=0.
  - Latency: req seen at edge t gives gnt visible after edge t.
  - done is ignored in IDLE.
- GRANT: gnt/gnt_idx stay stable. The grant releases on the first edge where any of these holds:
  - (a) done=1;
  - (b) req[owner]=0;
  - (c) timeout build only: hold_cnt==MAX_HOLD-1.
- On release:
  - state goes to IDLE, gnt=0, ptr<=owner, hold_cnt=0.
  - timeout=1 for one cycle only when (c) is the sole cause. When (a) or (b) coincide with (c), timeout stays 0.
  - Otherwise hold_cnt increments each GRANT cycle.
- Turnaround: at least one idle cycle (gnt=0) between successive grants, even to the same requester.
- Fairness: the released owner has the lowest priority at the next pick. A requester asserting req continuously waits at most 7 grants.
- Requests from non-owners during GRANT have no effect until IDLE.
- gnt is always one-hot or zero. gnt_idx always matches gnt.

Optional Feature:
- Macro RR_ARB8_TIMEOUT_EN.
- Defined: hold_cnt compare against MAX_HOLD is active, and timeout pulses as above.
- Undefined:
  - hold is unbounded and release is only by (a)/(b).
  - timeout is tied 0.
  - hold_cnt is not instantiated; MAX_HOLD and CNT_W are ignored.

Decomposition:
- Package rr_arb_pkg holds:
  - N_REQ=8, IDX_W=3;
  - state typedef with ST_IDLE=1'b0 and ST_GRANT=1'b1;
  - the one-hot/index conversion helper function.
- Sub-module rr_pick: purely combinational. Inputs are req and ptr; outputs are the winning index and a hit flag. Implemented as rotate-right by ptr+1, lowest-set-bit priority encode, then add back mod 8.

Test Plan:
- Reset, then req=8'b0000_0001 → after one edge gnt=8'b0000_0001, gnt_idx=0, gnt_valid=1; assert rst mid-grant → gnt=0 immediately, ptr=7.
- req=8'hFF held with done pulsed each grant → grant order 0,1,...,7,0; each grant is separated by exactly one cycle of gnt=0.
- Owner 3 granted, req=8'b1000_1000, then done → next grant goes to 7 (not 3); after 7 releases, 3 is granted again.
- Owner 5 granted, req[5] drops with done=0 → gnt=0 next edge, timeout=0, ptr=5.
- With RR_ARB8_TIMEOUT_EN, MAX_HOLD=4, req=8'b0000_0100, no done → gnt held 4 cycles, timeout pulses 1 cycle, and after 1 idle cycle requester 2 is re-granted. Repeat with done on the 4th cycle → timeout stays 0.
- done pulsed while IDLE with req=0 → no state change, all outputs remain 0.
